// File: rtl/au_sequencer.sv
// Aggregation-unit sequencer: walks the centroids, reads each NIT entry,
// fetches centroid + neighbour features from the PFT, and aligns the
// subtract/max datapath strobes so that one max-pooled result per centroid
// is presented downstream under a valid/ready handshake.
module au_sequencer #(
  parameter int NIT_addr_width  = 8,
  parameter int NIT_neighbor    = 16,
  parameter int NIT_point_index = 10,
  parameter int PFT_addr_width  = 10
) (
  input  logic                                            clk,
  input  logic                                            rstn,
  input  logic                                            start,
  input  logic [NIT_addr_width-1:0]                       num_centroid,
  output logic                                            busy,
  output logic                                            done,
  output logic [NIT_addr_width-1:0]                       nit_addr,
  input  logic [(NIT_neighbor+1)*NIT_point_index-1:0]     nit_dout,
  output logic [PFT_addr_width-1:0]                       pft_addr,
  output logic                                            pft_valid,
  output logic                                            pft_is_centroid,
  output logic                                            sub_en_centroid,
  output logic                                            sub_en_neighbor,
  output logic                                            max_en,
  output logic                                            max_first,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NIT_addr_width-1:0]                       out_centroid
);

  localparam int AW  = NIT_addr_width;
  localparam int N   = NIT_neighbor;
  localparam int IDX = NIT_point_index;
  localparam int PAW = PFT_addr_width;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NIT_RD, S_NIT_LAT, S_CEN, S_NBR, S_DRAIN, S_OUT, S_DONE
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     cnt_q;
  logic [AW-1:0]     c_q;
  logic [KW-1:0]     k_q;
  logic              dr_q;
  logic [N*IDX-1:0]  entry_q;      // neighbour slots only; centroid index is used straight off nit_dout
  logic              busy_q;
  logic              done_q;
  logic [PAW-1:0]    pft_addr_q;
  logic              pft_valid_q;
  logic              pft_cen_q;
  logic              nbr_q;
  logic              nbr_first_q;
  logic              out_valid_q;
  logic              cen_d1_q;
  logic              nbr_d1_q;
  logic              nbr_d2_q;
  logic              first_d1_q;
  logic              first_d2_q;
  logic [PAW-1:0]    nbr_next_d;

  // Address of the neighbour following the one currently being fetched.
  always_comb begin
    nbr_next_d = '0;
    if (int'(k_q) + 1 < N)
      nbr_next_d = PAW'(entry_q[IDX*(int'(k_q)+1) +: IDX]);
  end

  // Control FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      c_q         <= '0;
      k_q         <= '0;
      dr_q        <= 1'b0;
      entry_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pft_addr_q  <= '0;
      pft_valid_q <= 1'b0;
      pft_cen_q   <= 1'b0;
      nbr_q       <= 1'b0;
      nbr_first_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      pft_valid_q <= 1'b0;
      pft_cen_q   <= 1'b0;
      nbr_q       <= 1'b0;
      nbr_first_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_centroid == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= num_centroid;
              c_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= S_NIT_RD;
            end
          end
        end
        S_NIT_RD: state_q <= S_NIT_LAT;
        S_NIT_LAT: begin
          entry_q     <= nit_dout[(N+1)*IDX-1:IDX];
          pft_addr_q  <= PAW'(nit_dout[IDX-1:0]);
          pft_valid_q <= 1'b1;
          pft_cen_q   <= 1'b1;
          state_q     <= S_CEN;
        end
        S_CEN: begin
          k_q         <= '0;
          pft_addr_q  <= PAW'(entry_q[IDX-1:0]);
          pft_valid_q <= 1'b1;
          nbr_q       <= 1'b1;
          nbr_first_q <= 1'b1;
          state_q     <= S_NBR;
        end
        S_NBR: begin
          if (k_q == KW'(N-1)) begin
            dr_q    <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            k_q         <= k_q + 1'b1;
            pft_addr_q  <= nbr_next_d;
            pft_valid_q <= 1'b1;
            nbr_q       <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (dr_q) begin
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            dr_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (c_q == cnt_q - AW'(1)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              c_q     <= c_q + AW'(1);
              state_q <= S_NIT_RD;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobe delay pipes matching the PFT, subtract and max register stages.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cen_d1_q   <= 1'b0;
      nbr_d1_q   <= 1'b0;
      nbr_d2_q   <= 1'b0;
      first_d1_q <= 1'b0;
      first_d2_q <= 1'b0;
    end else begin
      cen_d1_q   <= pft_cen_q;
      nbr_d1_q   <= nbr_q;
      nbr_d2_q   <= nbr_d1_q;
      first_d1_q <= nbr_first_q;
      first_d2_q <= first_d1_q;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign nit_addr        = c_q;
  assign pft_addr        = pft_addr_q;
  assign pft_valid       = pft_valid_q;
  assign pft_is_centroid = pft_cen_q;
  assign sub_en_centroid = cen_d1_q;
  assign sub_en_neighbor = nbr_d1_q;
  assign max_en          = nbr_d2_q;
  assign max_first       = first_d2_q;
  assign out_valid       = out_valid_q;
  assign out_centroid    = c_q;

endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer with N=4: NIT/PFT memories plus a
// subtract/max datapath model (feature value = point index).
module tb_au_sequencer;

  localparam int AW  = 8;
  localparam int N   = 4;
  localparam int IDX = 10;
  localparam int PAW = 10;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start;
  logic [AW-1:0]          num_centroid;
  logic                   busy, done;
  logic [AW-1:0]          nit_addr;
  logic [(N+1)*IDX-1:0]   nit_dout;
  logic [PAW-1:0]         pft_addr;
  logic                   pft_valid, pft_is_centroid;
  logic                   sub_en_centroid, sub_en_neighbor, max_en, max_first;
  logic                   out_valid, out_ready;
  logic [AW-1:0]          out_centroid;

  au_sequencer #(
    .NIT_addr_width(AW), .NIT_neighbor(N), .NIT_point_index(IDX), .PFT_addr_width(PAW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_centroid(num_centroid),
    .busy(busy), .done(done), .nit_addr(nit_addr), .nit_dout(nit_dout),
    .pft_addr(pft_addr), .pft_valid(pft_valid), .pft_is_centroid(pft_is_centroid),
    .sub_en_centroid(sub_en_centroid), .sub_en_neighbor(sub_en_neighbor),
    .max_en(max_en), .max_first(max_first), .out_valid(out_valid),
    .out_ready(out_ready), .out_centroid(out_centroid)
  );

  always #5 clk = ~clk;

  // Memories and datapath model
  logic [(N+1)*IDX-1:0] nit_mem [256];
  logic [PAW-1:0]       pft_q;
  int                   cen_r, sub_r, max_r;

  always @(posedge clk) begin
    nit_dout <= nit_mem[nit_addr];
    pft_q    <= pft_addr;
    if (sub_en_centroid) cen_r <= int'(pft_q);
    if (sub_en_neighbor) sub_r <= int'(pft_q) - cen_r;
    if (max_en) max_r <= max_first ? sub_r : ((sub_r > max_r) ? sub_r : max_r);
  end

  // Running event totals; tasks compare differences
  int tot_max_en = 0, tot_first = 0, tot_done = 0, tot_pft = 0, tot_xfer = 0;
  always @(negedge clk) begin
    if (max_en) tot_max_en++;
    if (max_first) tot_first++;
    if (done) tot_done++;
    if (pft_valid) tot_pft++;
    if (out_valid && out_ready) tot_xfer++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; out_ready = 1'b0; num_centroid = '0;
    tick; tick;
    n_vec++;
    if ({busy, done, nit_addr, pft_addr, pft_valid, pft_is_centroid, sub_en_centroid,
         sub_en_neighbor, max_en, max_first, out_valid, out_centroid} !== '0) begin
      n_err++; $display("FAIL reset_outputs: some output nonzero (busy=%b pft_valid=%b out_valid=%b)",
                        busy, pft_valid, out_valid);
    end
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int exp_addr[5];
    int b_max, b_first, b_pft, b_done;
    exp_addr = '{9, 2, 3, 5, 7};
    b_max = tot_max_en; b_first = tot_first; b_pft = tot_pft; b_done = tot_done;
    num_centroid = 8'd1; out_ready = 1'b1; start = 1'b1;
    tick; start = 1'b0;                         // cycle 0: NIT_RD
    n_vec++;
    if (busy !== 1'b1 || nit_addr !== 8'd0) begin
      n_err++; $display("FAIL basic_nit_rd: busy=%b nit_addr=%0d, want 1/0", busy, nit_addr);
    end
    tick; tick;                                 // cycle 2: CEN
    n_vec++;
    if (pft_is_centroid !== 1'b1) begin
      n_err++; $display("FAIL basic_is_centroid: got %b want 1", pft_is_centroid);
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (pft_valid !== 1'b1 || pft_addr !== PAW'(exp_addr[i])) begin
        n_err++; $display("FAIL basic_pft_addr[%0d]: valid=%b addr=%0d want 1/%0d",
                          i, pft_valid, pft_addr, exp_addr[i]);
      end
      if (i == 1) begin
        n_vec++;
        if (sub_en_centroid !== 1'b1 || pft_is_centroid !== 1'b0) begin
          n_err++; $display("FAIL basic_sub_en_centroid: got %b want 1", sub_en_centroid);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (max_en !== 1'b1 || max_first !== 1'b1) begin
          n_err++; $display("FAIL basic_max_first: max_en=%b max_first=%b want 1/1", max_en, max_first);
        end
      end
      tick;
    end
    n_vec++;                                    // cycle 7: DRAIN0
    if (pft_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_drain_pft: got %b want 0", pft_valid);
    end
    tick;
    n_vec++;                                    // cycle 8: DRAIN1
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    tick;                                       // cycle 9: OUT
    n_vec++;
    if (out_valid !== 1'b1 || out_centroid !== 8'd0 || max_r !== -2) begin
      n_err++; $display("FAIL basic_out: valid=%b cen=%0d result=%0d want 1/0/-2",
                        out_valid, out_centroid, max_r);
    end
    tick;                                       // cycle 10: DONE
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_done: done=%b busy=%b valid=%b want 1/0/0", done, busy, out_valid);
    end
    tick;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse: got %b want 0", done);
    end
    n_vec++;
    if (tot_max_en - b_max !== 4 || tot_first - b_first !== 1 || tot_pft - b_pft !== 5 ||
        tot_done - b_done !== 1) begin
      n_err++; $display("FAIL basic_counts: max_en=%0d first=%0d pft=%0d done=%0d want 4/1/5/1",
                        tot_max_en - b_max, tot_first - b_first, tot_pft - b_pft, tot_done - b_done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int exp_res[3];
    int b_done, b_xfer, b_max, r0;
    exp_res = '{-2, 20, 1018};
    b_done = tot_done; b_xfer = tot_xfer; b_max = tot_max_en;
    num_centroid = 8'd3; out_ready = 1'b0; start = 1'b1;
    tick; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int w = 0; w < 40 && !out_valid; w++) tick;
      n_vec++;
      if (out_valid !== 1'b1 || out_centroid !== AW'(c) || max_r !== exp_res[c]) begin
        n_err++; $display("FAIL bp_out[%0d]: valid=%b cen=%0d result=%0d want 1/%0d/%0d",
                          c, out_valid, out_centroid, max_r, c, exp_res[c]);
      end
      r0 = max_r;
      for (int h = 0; h < 5; h++) begin
        tick;
        n_vec++;
        if (out_valid !== 1'b1 || max_en !== 1'b0 || pft_valid !== 1'b0 || max_r !== r0) begin
          n_err++; $display("FAIL bp_hold[%0d.%0d]: valid=%b max_en=%b pft=%b result=%0d want 1/0/0/%0d",
                            c, h, out_valid, max_en, pft_valid, max_r, r0);
        end
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL bp_done: got %b want 1", done);
    end
    tick; tick;
    n_vec++;
    if (tot_done - b_done !== 1 || tot_xfer - b_xfer !== 3 || tot_max_en - b_max !== 12) begin
      n_err++; $display("FAIL bp_counts: done=%0d xfer=%0d max_en=%0d want 1/3/12",
                        tot_done - b_done, tot_xfer - b_xfer, tot_max_en - b_max);
    end
  endtask

  task automatic test_zero;
    int b_pft;
    logic [AW-1:0] na;
    b_pft = tot_pft; na = nit_addr;
    num_centroid = 8'd0; start = 1'b1;
    tick; start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy);
    end
    tick;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || tot_pft !== b_pft || nit_addr !== na) begin
      n_err++; $display("FAIL zero_quiet: done=%b busy=%b pft=%0d nit_addr=%0d want 0/0/0/%0d",
                        done, busy, tot_pft - b_pft, nit_addr, na);
    end
  endtask

  task automatic test_ignore;
    int b_done, b_xfer, b_max;
    bit early;
    b_done = tot_done; b_xfer = tot_xfer; b_max = tot_max_en; early = 1'b0;
    num_centroid = 8'd2; out_ready = 1'b1; start = 1'b1;
    tick;                                       // cycle 0
    num_centroid = 8'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick;
      start = (cyc < 19);
      if (cyc < 20 && done) early = 1'b1;
      if (cyc == 9) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_centroid !== 8'd0) begin
          n_err++; $display("FAIL ign_out0: valid=%b cen=%0d want 1/0", out_valid, out_centroid);
        end
      end
      if (cyc == 19) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_centroid !== 8'd1 || max_r !== 20) begin
          n_err++; $display("FAIL ign_out1: valid=%b cen=%0d result=%0d want 1/1/20",
                            out_valid, out_centroid, max_r);
        end
      end
    end
    n_vec++;
    if (done !== 1'b1 || early) begin
      n_err++; $display("FAIL ign_done_time: done=%b early=%b want 1/0", done, early);
    end
    start = 1'b0;
    tick; tick;
    n_vec++;
    if (tot_done - b_done !== 1 || tot_xfer - b_xfer !== 2 || tot_max_en - b_max !== 8) begin
      n_err++; $display("FAIL ign_counts: done=%0d xfer=%0d max_en=%0d want 1/2/8",
                        tot_done - b_done, tot_xfer - b_xfer, tot_max_en - b_max);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_abort;
    int b_done;
    b_done = tot_done;
    num_centroid = 8'd2; out_ready = 1'b0; start = 1'b1;
    tick; start = 1'b0;                         // cycle 0
    repeat (4) tick;                            // cycle 4: NBR1
    rstn = 1'b0;
    tick;
    n_vec++;
    if ({busy, done, nit_addr, pft_addr, pft_valid, pft_is_centroid, sub_en_centroid,
         sub_en_neighbor, max_en, max_first, out_valid, out_centroid} !== '0) begin
      n_err++; $display("FAIL abort_outputs: busy=%b pft_valid=%b sub_en_n=%b max_en=%b want all 0",
                        busy, pft_valid, sub_en_neighbor, max_en);
    end
    rstn = 1'b1;
    repeat (20) tick;
    n_vec++;
    if (tot_done !== b_done || busy !== 1'b0 || out_valid !== 1'b0 || tot_pft < 0) begin
      n_err++; $display("FAIL abort_idle: done_pulses=%0d busy=%b valid=%b want 0/0/0",
                        tot_done - b_done, busy, out_valid);
    end
    num_centroid = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    n_vec++;
    if (nit_addr !== 8'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort_restart: nit_addr=%0d busy=%b want 0/1", nit_addr, busy);
    end
    for (int w = 0; w < 40 && !out_valid; w++) tick;
    n_vec++;
    if (out_valid !== 1'b1 || out_centroid !== 8'd0 || max_r !== -2) begin
      n_err++; $display("FAIL abort_rerun: valid=%b cen=%0d result=%0d want 1/0/-2",
                        out_valid, out_centroid, max_r);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL abort_rerun_done: got %b want 1", done);
    end
    tick;
  endtask

  initial begin
    // {n3, n2, n1, n0, centroid}
    nit_mem[0] = {10'd7, 10'd5, 10'd3, 10'd2, 10'd9};
    nit_mem[1] = {10'd50, 10'd120, 10'd120, 10'd90, 10'd100};
    nit_mem[2] = {10'd4, 10'd1023, 10'd0, 10'd1000, 10'd5};
    test_reset;
    test_basic;
    test_backpressure;
    test_zero;
    test_ignore;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
